aes_job_scheduler: RTL and testbench

//  Shares one AES-192 engine (aes_192_sed) between NUM_REQ requesters, e.g. CPU

---
 rtl/aes_sched_pkg.sv | 25 ++
 rtl/aes_rr_arb.sv | 34 +++
 rtl/aes_job_scheduler.sv | 157 +++++++++++++++
 tb/tb_aes_job_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler and its round-robin arbiter.
package aes_sched_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RESP
    } state_e;

    typedef logic [127:0] blk_t;
    typedef logic [1:0]   ksel_t;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned PTR_W       = $clog2(NUM_REQ_DEF);

    // Pointer width for an arbitrary requester count; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aes_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after the pointer.
module aes_rr_arb
    import aes_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES-192 engine between NUM_REQ requesters with round-robin arbitration.
// Optional watchdog on the engine wait is built when AES_SCHED_TIMEOUT_EN is defined.
module aes_job_scheduler
    import aes_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*128-1:0] req_pt_i,
    input  logic [NUM_REQ*2-1:0]   req_key_sel_i,
    input  logic                   req_lock_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    input  logic [NUM_REQ-1:0]     rsp_ready_i,
    output logic [127:0]           rsp_ct_o,
    output logic                   rsp_err_o,
    output logic                   aes_start_o,
    output logic [127:0]           aes_pt_o,
    output logic [1:0]             aes_key_sel_o,
    input  logic [127:0]           aes_ct_i,
    input  logic                   aes_ct_valid_i,
    output logic                   busy_o
);

    localparam int unsigned IDX_W = ptr_w(NUM_REQ);
    localparam int unsigned SET_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

    state_e               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic [SET_W-1:0]     settle_cnt;
    logic                 settle_done;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_found;
    logic                 grant;
    logic                 capture;
    logic                 timeout_hit;
    logic [NUM_REQ-1:0]   gnt_onehot;
    blk_t                 pt_sel;
    ksel_t                ks_sel;

    aes_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_valid_i),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // Accept is combinational so the job is taken in the very cycle the arbiter picks it.
    assign grant       = (state == S_IDLE) && !req_lock_i && arb_found;
    assign req_ready_o = grant ? arb_gnt : '0;
    assign busy_o      = (state != S_IDLE);
    assign pt_sel      = req_pt_i[32'(arb_idx)*128 +: 128];
    assign ks_sel      = req_key_sel_i[32'(arb_idx)*2 +: 2];
    assign gnt_onehot  = NUM_REQ'(1) << gnt_idx;
    assign settle_done = (32'(settle_cnt) >= SETTLE_CYC);
    assign capture     = (state == S_WAIT) && settle_done && aes_ct_valid_i;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign timeout_hit = (state == S_WAIT) && !capture && (32'(wd_cnt) >= TIMEOUT_CYC - 1);
    assign rsp_err_o   = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt <= '0;
        end else if (state == S_START) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT && !timeout_hit) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (grant || capture) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            gnt_idx       <= '0;
            settle_cnt    <= '0;
            aes_start_o   <= 1'b0;
            aes_pt_o      <= '0;
            aes_key_sel_o <= '0;
            rsp_valid_o   <= '0;
            rsp_ct_o      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant) begin
                        gnt_idx       <= arb_idx;
                        aes_pt_o      <= pt_sel;
                        aes_key_sel_o <= ks_sel;
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    aes_start_o <= 1'b1;
                    settle_cnt  <= '0;
                    state       <= S_START;
                end
                S_START: begin
                    aes_start_o <= 1'b0;
                    settle_cnt  <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture) begin
                        rsp_ct_o    <= aes_ct_i;
                        rsp_valid_o <= gnt_onehot;
                        state       <= S_RESP;
                    end else if (timeout_hit) begin
                        rsp_ct_o    <= '0;
                        rsp_valid_o <= gnt_onehot;
                        state       <= S_RESP;
                    end else if (!settle_done) begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i[gnt_idx]) begin
                        rsp_valid_o <= '0;
                        rr_ptr      <= IDX_W'((32'(gnt_idx) + 1) % NUM_REQ);
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Self-checking bench for aes_job_scheduler with a behavioural engine and scheduler model.
module tb_aes_job_scheduler;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int TO = 16;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [3:0]     req_valid_i;
    logic [3:0]     req_ready_o;
    logic [511:0]   req_pt_i;
    logic [7:0]     req_key_sel_i;
    logic           req_lock_i;
    logic [3:0]     rsp_valid_o;
    logic [3:0]     rsp_ready_i;
    logic [127:0]   rsp_ct_o;
    logic           rsp_err_o;
    logic           aes_start_o;
    logic [127:0]   aes_pt_o;
    logic [1:0]     aes_key_sel_o;
    logic [127:0]   aes_ct_i;
    logic           aes_ct_valid_i;
    logic           busy_o;

    int             n_cmp = 0;
    int             n_bad = 0;
    int             ptr_m;
    int             eng_lat;
    bit             stale_hold;
    logic [127:0]   pt_m [4];
    logic [1:0]     ks_m [4];

    aes_job_scheduler #(
        .NUM_REQ     (N),
        .SETTLE_CYC  (S),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_pt_i       (req_pt_i),
        .req_key_sel_i  (req_key_sel_i),
        .req_lock_i     (req_lock_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_ct_o       (rsp_ct_o),
        .rsp_err_o      (rsp_err_o),
        .aes_start_o    (aes_start_o),
        .aes_pt_o       (aes_pt_o),
        .aes_key_sel_o  (aes_key_sel_o),
        .aes_ct_i       (aes_ct_i),
        .aes_ct_valid_i (aes_ct_valid_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in cipher: bank 3 behaves as bank 2, like the real engine's key mux.
    function automatic logic [127:0] engine_f(input logic [127:0] pt, input logic [1:0] ks);
        logic [127:0] bank;
        case (ks)
            2'd0:    bank = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
            2'd1:    bank = 128'h13579bdf2468ace0fdb97531eca86420;
            default: bank = 128'hdeadbeefcafef00d0123456789abcdef;
        endcase
        return {pt[95:0], pt[127:96]} ^ bank;
    endfunction

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int pick(input logic [3:0] pend, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (pend[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    // Engine: valid eng_lat cycles after it sees start; eng_lat == 0 never answers.
    initial begin
        int           cnt;
        logic [127:0] p;
        logic [1:0]   k;
        cnt = 0;
        p = '0;
        k = '0;
        aes_ct_valid_i = 1'b0;
        aes_ct_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    aes_ct_valid_i = 1'b1;
                    aes_ct_i = engine_f(p, k);
                end
            end
            if (aes_start_o === 1'b1) begin
                if (!stale_hold) aes_ct_valid_i = 1'b0;
                cnt = eng_lat;
                p = aes_pt_o;
                k = aes_key_sel_o;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_ctrl"}, 128'({req_ready_o, rsp_valid_o, rsp_err_o, aes_start_o,
                                    aes_key_sel_o, busy_o}), '0);
        check({tag, "_ct"}, rsp_ct_o, '0);
        check({tag, "_pt"}, aes_pt_o, '0);
    endtask

    task automatic set_req(input int ch, input logic [127:0] pt, input logic [1:0] ks);
        pt_m[ch] = pt;
        ks_m[ch] = ks;
        req_pt_i[ch*128 +: 128] = pt;
        req_key_sel_i[ch*2 +: 2] = ks;
        req_valid_i[ch] = 1'b1;
    endtask

    // One job from grant to response handshake, checked against the scheduler model.
    task automatic do_job(input int lat, input bit drop, input int rdly, input bit lock_mid,
                          input bit exp_timeout);
        int           g, k, cyc, start_cyc, nstart, lat_exp;
        bit           spurious;
        logic [3:0]   oh;
        logic [127:0] ct_exp;
        eng_lat = lat;
        g = pick(req_valid_i, ptr_m);
        oh = 4'b0001 << g;
        k = 0;
        #1;
        while (req_ready_o === 4'b0 && k < 40) begin
            @(negedge clk_i);
            #1;
            k++;
        end
        check("grant", 128'(req_ready_o), 128'(oh));
        ct_exp  = exp_timeout ? '0 : engine_f(pt_m[g], ks_m[g]);
        lat_exp = exp_timeout ? 3 + TO : 4 + ((lat - 1 > S) ? lat - 1 : S);
        cyc = 0;
        start_cyc = -1;
        nstart = 0;
        spurious = 1'b0;
        while (rsp_valid_o === 4'b0 && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 1) begin
                if (drop) req_valid_i[g] = 1'b0;
                check("aes_pt", aes_pt_o, pt_m[g]);
                check("aes_ksel", 128'(aes_key_sel_o), 128'(ks_m[g]));
                check("err_clr", 128'(rsp_err_o), '0);
            end
            if (cyc == 3 && lock_mid) req_lock_i = 1'b1;
            if (aes_start_o === 1'b1) begin
                nstart++;
                start_cyc = cyc;
            end
            if (req_ready_o !== 4'b0) spurious = 1'b1;
        end
        check("start_count", 128'(nstart), 128'(1));
        check("start_cycle", 128'(start_cyc), 128'(2));
        check("no_accept_busy", 128'(spurious), '0);
        check("latency", 128'(cyc), 128'(lat_exp));
        check("rsp_valid", 128'(rsp_valid_o), 128'(oh));
        check("rsp_ct", rsp_ct_o, ct_exp);
        check("rsp_err", 128'(rsp_err_o), 128'(exp_timeout));
        for (int i = 0; i < rdly; i++) begin
            rsp_ready_i = 4'($urandom) & ~oh;
            @(negedge clk_i);
            check("hold_valid", 128'(rsp_valid_o), 128'(oh));
            check("hold_ct", rsp_ct_o, ct_exp);
            check("hold_no_grant", 128'(req_ready_o), '0);
        end
        rsp_ready_i = oh | 4'($urandom);
        @(negedge clk_i);
        rsp_ready_i = '0;
        req_lock_i = 1'b0;
        check("idle_after_hs", 128'({busy_o, rsp_valid_o}), '0);
        ptr_m = (g + 1) % N;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int g;
        req_valid_i = '0;
        req_pt_i = '0;
        req_key_sel_i = '0;
        req_lock_i = 1'b0;
        rsp_ready_i = '0;
        rst_ni = 1'b0;
        eng_lat = 1;
        stale_hold = 1'b0;
        ptr_m = 0;
        repeat (3) @(negedge clk_i);
        check_zero_outs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Fairness: all channels held valid, five back-to-back jobs.
        for (int ch = 0; ch < N; ch++) set_req(ch, rnd(), 2'(ch));
        for (int j = 0; j < 5; j++) do_job(4 + j, 1'b0, 0, 1'b0, 1'b0);
        req_valid_i = '0;

        // Single job on channel 1 with a fixed block and 12-cycle engine.
        set_req(1, 128'h00112233445566778899aabbccddeeff, 2'd1);
        do_job(12, 1'b1, 0, 1'b0, 1'b0);

        // Backpressure on channel 2 with others waiting, then key bank 3 forwarding.
        set_req(2, rnd(), 2'd2);
        set_req(3, rnd(), 2'd3);
        set_req(0, rnd(), 2'd0);
        do_job(5, 1'b1, 20, 1'b0, 1'b0);
        do_job(7, 1'b1, 1, 1'b0, 1'b0);
        do_job(2, 1'b1, 0, 1'b0, 1'b0);

        // Stale engine valid held across start; new result lands right at settle end.
        stale_hold = 1'b1;
        set_req(1, rnd(), 2'd2);
        do_job(3, 1'b1, 0, 1'b0, 1'b0);
        stale_hold = 1'b0;

        // Lock blocks grants while requests are pending.
        req_lock_i = 1'b1;
        set_req(0, rnd(), 2'd1);
        set_req(3, rnd(), 2'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            #1;
            check("lock_no_grant", 128'({busy_o, req_ready_o}), '0);
        end
        @(negedge clk_i);
        req_lock_i = 1'b0;
        do_job(4, 1'b1, 0, 1'b0, 1'b0);
        do_job(1, 1'b1, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        set_req(2, rnd() | 128'h1, 2'd1);
        eng_lat = 50;
        #1;
        g = 0;
        while (req_ready_o === 4'b0 && g < 40) begin
            @(negedge clk_i);
            #1;
            g++;
        end
        check("rst_job_grant", 128'(req_ready_o), 128'(4'b0100));
        @(negedge clk_i);
        req_valid_i = '0;
        repeat (4) @(negedge clk_i);
        check("wait_busy", 128'(busy_o), 128'(1));
        rst_ni = 1'b0;
        #1;
        check_zero_outs("async_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        ptr_m = 0;
        #1;
        check("idle_after_rst", 128'(busy_o), '0);
        @(negedge clk_i);
        set_req(1, rnd(), 2'd0);
        set_req(3, rnd(), 2'd2);
        do_job(6, 1'b1, 0, 1'b0, 1'b0);
        do_job(2, 1'b1, 2, 1'b0, 1'b0);

`ifdef AES_SCHED_TIMEOUT_EN
        // Engine never answers: watchdog aborts, next grant clears the error.
        set_req(0, rnd(), 2'd1);
        do_job(0, 1'b1, 3, 1'b0, 1'b1);
        set_req(1, rnd(), 2'd2);
        do_job(3, 1'b1, 0, 1'b0, 1'b0);
`endif

        // Randomized traffic: arrivals, engine latency, backpressure, mid-job lock.
        for (int j = 0; j < 40; j++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (!req_valid_i[ch] && $urandom_range(1, 0) == 1) set_req(ch, rnd(), 2'($urandom));
            end
            if (req_valid_i == 4'b0) set_req(int'($urandom_range(3, 0)), rnd(), 2'($urandom));
            do_job(int'($urandom_range(14, 1)), 1'b1, int'($urandom_range(4, 0)),
                   1'($urandom_range(1, 0)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
